video_timing_detector: RTL and testbench

VIDEO_TIMING_DETECTOR -- requirements
Module: video_timing_detector

---
 rtl/video_timing_detector.sv | 179 +++++++++++++++++
 tb/tb_video_timing_detector.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_detector.sv
// Video timing detector: measures line/frame geometry from hs/vs/de, locks after
// LOCK_FRAMES identical frames and emits registered active-pixel coordinates.
module video_timing_detector #(
  parameter logic        HS_ACTIVE_LOW = 1'b1,
  parameter logic        VS_ACTIVE_LOW = 1'b1,
  parameter int unsigned LOCK_FRAMES   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_active,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_valid,
  output logic        o_locked,
  output logic [10:0] o_h_total,
  output logic [10:0] o_h_active,
  output logic [10:0] o_v_total,
  output logic [10:0] o_v_active,
  output logic        o_frame_start,
  output logic        o_error
);

  localparam logic [10:0] CNT_MAX = '1;
  localparam int unsigned MW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {SEARCH, BASELINE, VERIFY, LOCKED} state_t;

  state_t        r_state;
  logic          r_hs_prev, r_vs_prev;
  logic [10:0]   r_h_cnt, r_a_cnt, r_v_cnt, r_va_cnt;
  logic [10:0]   r_len_ref, r_act_ref;
  logic          r_have_len, r_have_act, r_bad;
  logic [10:0]   r_ref_h_total, r_ref_h_active, r_ref_v_total, r_ref_v_active;
  logic [MW-1:0] r_match;

  logic          w_hs, w_vs, w_hs_edge, w_vs_edge, w_h_sat;
  logic [10:0]   w_line_len, w_v_cnt_cl, w_va_cnt_cl, w_len_ref_cl, w_act_ref_cl;
  logic          w_line_act, w_line_bad, w_bad_cl, w_frame_good, w_frame_match;
  logic [MW-1:0] w_match_inc;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

  assign w_hs      = i_hs ^ HS_ACTIVE_LOW;
  assign w_vs      = i_vs ^ VS_ACTIVE_LOW;
  assign w_hs_edge = i_pix_stb & w_hs & ~r_hs_prev;
  assign w_vs_edge = i_pix_stb & w_vs & ~r_vs_prev;

  assign w_line_len = sat_inc(r_h_cnt);
  assign w_h_sat    = i_pix_stb & ~w_hs_edge & (r_h_cnt == CNT_MAX - 11'd1);
  assign w_line_act = (r_a_cnt != '0);

  // The "closed" (_cl) values fold a coincident hs edge into the frame before a vs edge latches it.
  // The active reference is the first line of the frame that carried any active strobes.
  assign w_line_bad   = (r_have_len & (w_line_len != r_len_ref)) |
                        (w_line_act & r_have_act & (r_a_cnt != r_act_ref));
  assign w_v_cnt_cl   = w_hs_edge ? sat_inc(r_v_cnt) : r_v_cnt;
  assign w_va_cnt_cl  = (w_hs_edge & w_line_act) ? sat_inc(r_va_cnt) : r_va_cnt;
  assign w_len_ref_cl = (w_hs_edge & ~r_have_len) ? w_line_len : r_len_ref;
  assign w_act_ref_cl = (w_hs_edge & w_line_act & ~r_have_act) ? r_a_cnt : r_act_ref;
  assign w_bad_cl     = r_bad | (w_hs_edge & w_line_bad) | w_h_sat | (w_v_cnt_cl == CNT_MAX);

  assign w_frame_good  = ~w_bad_cl & (r_have_len | w_hs_edge);
  assign w_frame_match = (w_len_ref_cl == r_ref_h_total) & (w_act_ref_cl == r_ref_h_active) &
                         (w_v_cnt_cl == r_ref_v_total) & (w_va_cnt_cl == r_ref_v_active);
  assign w_match_inc   = r_match + MW'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hs_prev  <= 1'b0;
      r_vs_prev  <= 1'b0;
      r_h_cnt    <= '0;
      r_a_cnt    <= '0;
      r_v_cnt    <= '0;
      r_va_cnt   <= '0;
      r_len_ref  <= '0;
      r_act_ref  <= '0;
      r_have_len <= 1'b0;
      r_have_act <= 1'b0;
      r_bad      <= 1'b0;
      o_x        <= '0;
      o_y        <= '0;
      o_valid    <= 1'b0;
    end else if (i_pix_stb) begin
      r_hs_prev <= w_hs;
      r_vs_prev <= w_vs;
      if (w_hs_edge) begin
        r_h_cnt <= '0;
        r_a_cnt <= {10'd0, i_active};
      end else begin
        r_h_cnt <= w_line_len;
        if (i_active) r_a_cnt <= sat_inc(r_a_cnt);
      end
      if (w_vs_edge) begin
        r_v_cnt    <= '0;
        r_va_cnt   <= '0;
        r_len_ref  <= '0;
        r_act_ref  <= '0;
        r_have_len <= 1'b0;
        r_have_act <= 1'b0;
        r_bad      <= 1'b0;
      end else begin
        r_v_cnt    <= w_v_cnt_cl;
        r_va_cnt   <= w_va_cnt_cl;
        r_len_ref  <= w_len_ref_cl;
        r_act_ref  <= w_act_ref_cl;
        r_have_len <= r_have_len | w_hs_edge;
        r_have_act <= r_have_act | (w_hs_edge & w_line_act);
        r_bad      <= w_bad_cl;
      end
      o_x     <= w_hs_edge ? '0 : r_a_cnt[9:0];
      o_y     <= w_vs_edge ? '0 : w_va_cnt_cl[9:0];
      o_valid <= i_active & o_locked;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= SEARCH;
      r_match        <= '0;
      r_ref_h_total  <= '0;
      r_ref_h_active <= '0;
      r_ref_v_total  <= '0;
      r_ref_v_active <= '0;
      o_locked       <= 1'b0;
      o_h_total      <= '0;
      o_h_active     <= '0;
      o_v_total      <= '0;
      o_v_active     <= '0;
      o_frame_start  <= 1'b0;
      o_error        <= 1'b0;
    end else begin
      o_frame_start <= w_vs_edge;
      o_error       <= 1'b0;
      case (r_state)
        SEARCH: if (w_vs_edge) r_state <= BASELINE;
        BASELINE: if (w_vs_edge) begin
          r_ref_h_total  <= w_len_ref_cl;
          r_ref_h_active <= w_act_ref_cl;
          r_ref_v_total  <= w_v_cnt_cl;
          r_ref_v_active <= w_va_cnt_cl;
          r_match        <= '0;
          r_state        <= VERIFY;
        end
        VERIFY: if (w_vs_edge) begin
          if (w_frame_good & w_frame_match) begin
            r_match <= w_match_inc;
            if (w_match_inc == MW'(LOCK_FRAMES)) begin
              r_state    <= LOCKED;
              o_locked   <= 1'b1;
              o_h_total  <= r_ref_h_total;
              o_h_active <= r_ref_h_active;
              o_v_total  <= r_ref_v_total;
              o_v_active <= r_ref_v_active;
            end
          end else begin
            r_ref_h_total  <= w_len_ref_cl;
            r_ref_h_active <= w_act_ref_cl;
            r_ref_v_total  <= w_v_cnt_cl;
            r_ref_v_active <= w_va_cnt_cl;
            r_match        <= '0;
          end
        end
        LOCKED: if (w_h_sat | (w_vs_edge & ~(w_frame_good & w_frame_match))) begin
          o_error  <= 1'b1;
          o_locked <= 1'b0;
          r_match  <= '0;
          r_state  <= SEARCH;
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_video_timing_detector.sv
// Scoreboard bench for video_timing_detector using a reduced 48x20 raster
// (32x12 active, hs at 36..41, vs edge coincident with the line-14 hs edge).
module tb_video_timing_detector;

  localparam int H_TOT = 48, H_ACT = 32, HS0 = 36, HS1 = 42;
  localparam int V_TOT = 20, V_ACT = 12, VS0 = 14, VS1 = 16;
  localparam int LOCK_EDGES = 4;

  logic        clk = 1'b0;
  logic        rst, i_pix_stb, i_hs, i_vs, i_active;
  logic [9:0]  o_x, o_y;
  logic        o_valid, o_locked, o_frame_start, o_error;
  logic [10:0] o_h_total, o_h_active, o_v_total, o_v_active;

  always #5 clk = ~clk;

  video_timing_detector #(.HS_ACTIVE_LOW(1'b1), .VS_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(i_pix_stb), .i_hs(i_hs), .i_vs(i_vs),
    .i_active(i_active), .o_x(o_x), .o_y(o_y), .o_valid(o_valid), .o_locked(o_locked),
    .o_h_total(o_h_total), .o_h_active(o_h_active), .o_v_total(o_v_total),
    .o_v_active(o_v_active), .o_frame_start(o_frame_start), .o_error(o_error)
  );

  typedef struct packed { logic [9:0] x; logic [9:0] y; } pix_t;
  pix_t exp_q[$];

  int checks = 0, failures = 0;
  int stride = 1, acq_cnt = 0, exp_err = 0, err_seen = 0, fs_gen = 0, fs_seen = 0;
  bit exp_locked = 1'b0;
  logic stb_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: outputs reflect the strobe sampled at the previous rising edge.
  always @(posedge clk) stb_q <= i_pix_stb;

  initial forever begin
    pix_t e;
    @(negedge clk);
    if (o_error === 1'b1) err_seen++;
    if (o_frame_start === 1'b1) fs_seen++;
    if (stb_q && o_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pix_unexpected actual x=%0d y=%0d required=no pixel", o_x, o_y);
      end else begin
        e = exp_q.pop_front();
        if ({o_x, o_y} !== {e.x, e.y}) begin
          failures++;
          $display("FAIL pix_xy actual x=%0d y=%0d required x=%0d y=%0d", o_x, o_y, e.x, e.y);
        end
      end
    end
  end

  task automatic send(input logic hsa, input logic vsa, input logic act);
    i_pix_stb = 1'b1;
    i_hs      = ~hsa;
    i_vs      = ~vsa;
    i_active  = act;
    @(posedge clk); #1;
    for (int k = 1; k < stride; k++) begin
      i_pix_stb = 1'b0;
      i_hs      = 1'($urandom);
      i_vs      = 1'($urandom);
      i_active  = 1'($urandom);
      @(posedge clk); #1;
    end
    i_pix_stb = 1'b0;
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_h_total"},  o_h_total,  H_TOT);
    check({tag, "_h_active"}, o_h_active, H_ACT);
    check({tag, "_v_total"},  o_v_total,  V_TOT);
    check({tag, "_v_active"}, o_v_active, V_ACT);
  endtask

  task automatic send_frame(input int n_lines, input int stretch_line);
    logic hsa, vsa, act;
    bit   bad_seen;
    bad_seen = 1'b0;
    for (int l = 0; l < n_lines; l++) begin
      for (int h = 0; h < H_TOT + ((l == stretch_line) ? 1 : 0); h++) begin
        hsa = (h >= HS0) && (h < HS1);
        vsa = (l == VS0 && h >= HS0) || (l > VS0 && l < VS1) || (l == VS1 && h < HS0);
        act = (l < V_ACT) && (h < H_ACT);
        if (act && exp_locked) exp_q.push_back(pix_t'{x: 10'(h), y: 10'(l)});
        send(hsa, vsa, act);
        if (l == stretch_line) bad_seen = 1'b1;
        if (l == VS0 && h == HS0) begin
          fs_gen++;
          acq_cnt++;
          if (bad_seen && exp_locked) begin
            exp_locked = 1'b0;
            exp_err++;
            acq_cnt = 0;
            check("err_unlock", o_locked, 0);
            check("hold_h_total", o_h_total, H_TOT);
          end else begin
            if (acq_cnt == LOCK_EDGES) begin
              exp_locked = 1'b1;
              check_totals("lock");
            end
            check("locked_at_vs", o_locked, exp_locked);
          end
        end
      end
    end
  endtask

  task automatic stall_hsync();
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    for (int k = 1; k <= 3000 && !hit; k++) begin
      send(1'b0, 1'b0, 1'b0);
      n = k;
      if (o_error === 1'b1) hit = 1'b1;
    end
    check("hsat_strobes", n, 2036);
    check("hsat_unlock", o_locked, 0);
    exp_locked = 1'b0;
    acq_cnt    = 0;
    exp_err++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_pix_stb = 1'b0; i_hs = 1'b1; i_vs = 1'b1; i_active = 1'b0;
    @(posedge clk); #1;
    check("rst_locked", o_locked, 0);
    check("rst_valid", o_valid, 0);
    check("rst_h_total", o_h_total, 0);
    check("rst_xy", {o_x, o_y}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full-rate acquisition, then a stretched line while locked, then re-lock.
    repeat (5) send_frame(V_TOT, -1);
    send_frame(V_TOT, 3);
    repeat (5) send_frame(V_TOT, -1);
    check("err_pulse_stretch", err_seen, exp_err);

    stall_hsync();
    repeat (5) send_frame(V_TOT, -1);
    check("err_pulse_stall", err_seen, exp_err);

    // Reset while locked, partway through the frame.
    send_frame(13, -1);
    rst = 1'b1;
    #1;
    check("mrst_locked", o_locked, 0);
    check("mrst_valid", o_valid, 0);
    check("mrst_y", o_y, 0);
    check("mrst_h_total", o_h_total, 0);
    check("mrst_v_active", o_v_active, 0);
    check("mrst_error", o_error, 0);
    exp_locked = 1'b0;
    acq_cnt    = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) send_frame(V_TOT, -1);
    check("mrst_no_error", err_seen, exp_err);

    // Quarter-rate strobe with garbage on the inputs between strobes.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_locked = 1'b0;
    acq_cnt    = 0;
    stride     = 4;
    repeat (5) send_frame(V_TOT, -1);

    repeat (4) @(posedge clk);
    check("pix_drained", exp_q.size(), 0);
    check("frame_starts", fs_seen, fs_gen);
    check("err_total", err_seen, exp_err);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
